// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM frame scheduler.
package pcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ARMED = 2'd3
  } pcm_state_e;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [DW_DEF-1:0] MUTE_WORD = 32'h0000_0000;

endpackage

// File: rtl/pcm_tick_gen.sv
// Sample-tick divider: counts 0..max(div,1)-1 while running and pulses tick on the
// terminal count; held at zero while stopped or restarting.
module pcm_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_s;

  // Next count and tick; >= keeps a shrinking divisor from running off the end.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (div < DIV_W'(2)) begin
      last_s = {DIV_W{1'b0}};
    end else begin
      last_s = div - DIV_W'(1);
    end
    if (restart || !run) begin
      cnt_d = {DIV_W{1'b0}};
    end else if (cnt_q >= last_s) begin
      cnt_d = {DIV_W{1'b0}};
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pcm_frame_sched.sv
// Pairs L/R PCM FIFO words into stereo frames and releases one frame per sample tick.
// Build option: define PCM_HOLD_LAST_EN to re-present the last frame on underrun instead of mute.
module pcm_frame_sched
  import pcm_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] osr_div,
  input  logic             cnt_clr,
  input  logic             l_empty,
  input  logic             r_empty,
  input  logic [DW-1:0]    l_dout,
  input  logic [DW-1:0]    r_dout,
  output logic             l_rd_en,
  output logic             r_rd_en,
  output logic [DW-1:0]    out_l,
  output logic [DW-1:0]    out_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] late_cnt,
  output logic             busy
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  pcm_state_e       state_q, state_d;
  logic [1:0]       lat_q, lat_d;
  logic [DW-1:0]    stage_l_q, stage_l_d;
  logic [DW-1:0]    stage_r_q, stage_r_d;
  logic             stage_valid_q, stage_valid_d;
  logic [DW-1:0]    out_l_q, out_l_d;
  logic [DW-1:0]    out_r_q, out_r_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] und_q, und_d;
  logic [CNT_W-1:0] late_q, late_d;

  logic             tick_s;
  logic             tick_eff_s;
  logic             rd_s;
  logic             und_inc_s;
  logic             late_inc_s;
  logic [DW-1:0]    und_l_s;
  logic [DW-1:0]    und_r_s;

  pcm_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q != ST_IDLE),
    .restart ((state_q == ST_IDLE) && enable),
    .div     (osr_div),
    .tick    (tick_s)
  );

  // Next-state, frame and counter logic.
  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    stage_l_d     = stage_l_q;
    stage_r_d     = stage_r_q;
    stage_valid_d = stage_valid_q;
    out_l_d       = out_l_q;
    out_r_d       = out_r_q;
    out_valid_d   = out_valid_q;
    und_d         = und_q;
    late_d        = late_q;
    rd_s          = 1'b0;

`ifdef PCM_HOLD_LAST_EN
    und_l_s = out_l_q;
    und_r_s = out_r_q;
`else
    und_l_s = DW'(MUTE_WORD);
    und_r_s = DW'(MUTE_WORD);
`endif

    // A stopping block ignores ticks, except while a read is still landing in LOAD.
    tick_eff_s = tick_s && (enable || (state_q == ST_LOAD));
    und_inc_s  = tick_eff_s && ((state_q == ST_FILL) || (state_q == ST_LOAD));
    late_inc_s = tick_eff_s && out_valid_q && !out_ready;

    case (state_q)
      ST_IDLE: begin
        stage_valid_d = 1'b0;
        if (enable) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!l_empty && !r_empty) begin
          rd_s    = 1'b1;
          lat_d   = 2'd0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_LOAD: begin
        if (lat_q == LAT_LAST) begin
          stage_l_d     = l_dout;
          stage_r_d     = r_dout;
          stage_valid_d = enable;
          state_d       = enable ? ST_ARMED : ST_IDLE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          stage_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (tick_s) begin
          stage_valid_d = 1'b0;
          state_d       = ST_FILL;
        end else begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        stage_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase

    // A tick always wins over acceptance so a coinciding handshake keeps valid high.
    if (tick_eff_s) begin
      out_valid_d = 1'b1;
      if (state_q == ST_ARMED) begin
        out_l_d = stage_l_q;
        out_r_d = stage_r_q;
      end else begin
        out_l_d = und_l_s;
        out_r_d = und_r_s;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (cnt_clr) begin
      und_d = {CNT_W{1'b0}};
    end else if (und_inc_s && !(&und_q)) begin
      und_d = und_q + CNT_W'(1);
    end else begin
      und_d = und_q;
    end

    if (cnt_clr) begin
      late_d = {CNT_W{1'b0}};
    end else if (late_inc_s && !(&late_q)) begin
      late_d = late_q + CNT_W'(1);
    end else begin
      late_d = late_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lat_q         <= 2'd0;
      stage_l_q     <= {DW{1'b0}};
      stage_r_q     <= {DW{1'b0}};
      stage_valid_q <= 1'b0;
      out_l_q       <= {DW{1'b0}};
      out_r_q       <= {DW{1'b0}};
      out_valid_q   <= 1'b0;
      und_q         <= {CNT_W{1'b0}};
      late_q        <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      stage_l_q     <= stage_l_d;
      stage_r_q     <= stage_r_d;
      stage_valid_q <= stage_valid_d;
      out_l_q       <= out_l_d;
      out_r_q       <= out_r_d;
      out_valid_q   <= out_valid_d;
      und_q         <= und_d;
      late_q        <= late_d;
    end
  end

  // The read strobe is decoded from FILL so the FIFO latency lines up with LOAD.
  assign l_rd_en      = rd_s;
  assign r_rd_en      = rd_s;
  assign out_l        = out_l_q;
  assign out_r        = out_r_q;
  assign out_valid    = out_valid_q;
  assign underrun_cnt = und_q;
  assign late_cnt     = late_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcm_frame_sched.sv
// Directed bench for pcm_frame_sched with FIFO models and a frame scoreboard.
module tb_pcm_frame_sched;

  localparam int DW = 32;
  localparam int DIV_W = 16;
  localparam int RD_LAT = 3;
  localparam int CNT_W = 4;
`ifdef PCM_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [DIV_W-1:0] osr_div = 16'd8;
  logic cnt_clr = 1'b0;
  logic l_empty = 1'b1;
  logic r_empty = 1'b1;
  logic [DW-1:0] lp [RD_LAT];
  logic [DW-1:0] rp [RD_LAT];
  logic l_rd_en, r_rd_en;
  logic [DW-1:0] out_l, out_r;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [CNT_W-1:0] underrun_cnt, late_cnt;
  logic busy;

  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  frame_t exp_q[$];
  int frame_cyc[$];
  int n_checks = 0;
  int n_errors = 0;
  int frames_seen = 0;
  int rd_cnt = 0;
  int cyc = 0;
  bit sb_en = 1'b1;
  bit prev_valid = 1'b0;
  logic [DW-1:0] last_l = 32'h0;
  logic [DW-1:0] last_r = 32'h0;
  logic [DW-1:0] ul, ur;

  pcm_frame_sched #(
    .DW(DW), .DIV_W(DIV_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .osr_div(osr_div), .cnt_clr(cnt_clr),
    .l_empty(l_empty), .r_empty(r_empty), .l_dout(lp[RD_LAT-1]), .r_dout(rp[RD_LAT-1]),
    .l_rd_en(l_rd_en), .r_rd_en(r_rd_en), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .out_ready(out_ready), .underrun_cnt(underrun_cnt),
    .late_cnt(late_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO models: read latency RD_LAT, empty flags registered at the clock edge.
  always @(posedge clk) begin
    if (l_rd_en) lp[0] <= lq.pop_front();
    if (r_rd_en) rp[0] <= rq.pop_front();
    for (int i = 1; i < RD_LAT; i++) begin
      lp[i] <= lp[i-1];
      rp[i] <= rp[i-1];
    end
    l_empty <= (lq.size() == 0);
    r_empty <= (rq.size() == 0);
  end

  // Output monitor: strobe pairing, read count, scoreboard on each new frame.
  always @(posedge clk) begin
    #2;
    cyc++;
    chk("rd_en_pair", {63'd0, l_rd_en}, {63'd0, r_rd_en});
    if (l_rd_en || r_rd_en) rd_cnt++;
    if (sb_en && out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", {out_l, out_r}, 64'h0);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        chk("frame_data", {out_l, out_r}, {e.l, e.r});
      end
      frame_cyc.push_back(cyc);
      frames_seen++;
    end
    prev_valid = out_valid;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_fifo(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit do_l, input bit do_r);
    if (do_l) lq.push_back(l);
    if (do_r) rq.push_back(r);
  endtask

  task automatic push_exp(input logic [DW-1:0] l, input logic [DW-1:0] r);
    frame_t e;
    e.l = l;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_frames(input string tag, input int target, input int bound);
    int k;
    k = 0;
    while (frames_seen < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(frames_seen), 64'(target));
  endtask

  task automatic clear_test();
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    frames_seen = 0;
    rd_cnt = 0;
    frame_cyc.delete();
  endtask

  initial begin
    int k;
    for (int i = 0; i < RD_LAT; i++) begin
      lp[i] = 32'h0;
      rp[i] = 32'h0;
    end
    step(3);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_lr", {out_l, out_r}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rd_en", {63'd0, l_rd_en}, 64'd0);
    chk("rst_underrun", 64'(underrun_cnt), 64'd0);
    chk("rst_late", 64'(late_cnt), 64'd0);
    rst = 1'b0;
    step(2);

    // Basic streaming: 4 pairs, one frame per 8 cycles.
    clear_test();
    osr_div = 16'd8;
    for (int i = 0; i < 4; i++) begin
      push_fifo(32'h100 + 32'(i), 32'h200 + 32'(i), 1'b1, 1'b1);
      push_exp(32'h100 + 32'(i), 32'h200 + 32'(i));
    end
    enable = 1'b1;
    wait_frames("t1_frames", 4, 200);
    enable = 1'b0;
    for (int i = 1; i < 4; i++)
      chk("t1_spacing", 64'(frame_cyc[i] - frame_cyc[i-1]), 64'd8);
    chk("t1_underrun", 64'(underrun_cnt), 64'd0);
    chk("t1_rd_count", 64'(rd_cnt), 64'd4);
    last_l = 32'h103;
    last_r = 32'h203;
    step(4);
    chk("t1_idle", {63'd0, busy}, 64'd0);

    // Underrun with empty FIFOs.
    clear_test();
    osr_div = 16'd4;
    ul = HOLD ? last_l : 32'h0;
    ur = HOLD ? last_r : 32'h0;
    for (int i = 0; i < 3; i++) push_exp(ul, ur);
    enable = 1'b1;
    wait_frames("t2_frames", 3, 100);
    enable = 1'b0;
    chk("t2_underrun", 64'(underrun_cnt), 64'd3);
    last_l = ul;
    last_r = ur;
    step(4);

    // One real frame then underruns.
    clear_test();
    osr_div = 16'd8;
    push_fifo(32'hAAAA, 32'h5555, 1'b1, 1'b1);
    push_exp(32'hAAAA, 32'h5555);
    ul = HOLD ? 32'hAAAA : 32'h0;
    ur = HOLD ? 32'h5555 : 32'h0;
    push_exp(ul, ur);
    push_exp(ul, ur);
    enable = 1'b1;
    wait_frames("t2b_frames", 3, 100);
    enable = 1'b0;
    chk("t2b_underrun", 64'(underrun_cnt), 64'd2);
    last_l = ul;
    last_r = ur;
    step(4);

    // Skew: left only, then right words arrive.
    clear_test();
    push_fifo(32'h300, 32'h0, 1'b1, 1'b0);
    push_fifo(32'h301, 32'h0, 1'b1, 1'b0);
    ul = HOLD ? last_l : 32'h0;
    ur = HOLD ? last_r : 32'h0;
    push_exp(ul, ur);
    push_exp(ul, ur);
    enable = 1'b1;
    wait_frames("t3_under_frames", 2, 100);
    chk("t3_no_rd", 64'(rd_cnt), 64'd0);
    push_fifo(32'h0, 32'h400, 1'b0, 1'b1);
    push_fifo(32'h0, 32'h401, 1'b0, 1'b1);
    push_exp(32'h300, 32'h400);
    push_exp(32'h301, 32'h401);
    wait_frames("t3_frames", 4, 100);
    enable = 1'b0;
    chk("t3_underrun", 64'(underrun_cnt), 64'd2);
    chk("t3_rd_count", 64'(rd_cnt), 64'd2);
    last_l = 32'h301;
    last_r = 32'h401;
    step(4);

    // Backpressure: late ticks overwrite, then tick coincides with acceptance.
    clear_test();
    out_ready = 1'b0;
    push_fifo(32'h500, 32'h600, 1'b1, 1'b1);
    push_fifo(32'h501, 32'h601, 1'b1, 1'b1);
    push_exp(32'h500, 32'h600);
    enable = 1'b1;
    k = 0;
    while (!out_valid && k < 50) begin
      step(1);
      k++;
    end
    chk("t4_first_valid", {63'd0, out_valid}, 64'd1);
    step(4);
    chk("t4_stable", {out_l, out_r}, {32'h500, 32'h600});
    chk("t4_stable_valid", {63'd0, out_valid}, 64'd1);
    step(4);
    chk("t4_overwrite", {out_l, out_r}, {32'h501, 32'h601});
    chk("t4_late1", 64'(late_cnt), 64'd1);
    step(8);
    ul = HOLD ? 32'h501 : 32'h0;
    ur = HOLD ? 32'h601 : 32'h0;
    chk("t4_newest", {out_l, out_r}, {ul, ur});
    chk("t4_late2", 64'(late_cnt), 64'd2);
    chk("t4_underrun1", 64'(underrun_cnt), 64'd1);
    step(7);
    out_ready = 1'b1;
    step(1);
    chk("t4_coincide_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_coincide_late", 64'(late_cnt), 64'd2);
    chk("t4_underrun2", 64'(underrun_cnt), 64'd2);
    chk("t4_coincide_data", {out_l, out_r}, {ul, ur});
    step(1);
    chk("t4_valid_fall", {63'd0, out_valid}, 64'd0);
    enable = 1'b0;
    step(4);

    // Disable during LOAD.
    clear_test();
    push_fifo(32'h700, 32'h800, 1'b1, 1'b1);
    enable = 1'b1;
    k = 0;
    while (!l_rd_en && k < 20) begin
      step(1);
      k++;
    end
    chk("t5_rd_seen", {63'd0, l_rd_en}, 64'd1);
    step(1);
    enable = 1'b0;
    step(1);
    chk("t5_busy_load2", {63'd0, busy}, 64'd1);
    step(1);
    chk("t5_busy_load3", {63'd0, busy}, 64'd1);
    step(1);
    chk("t5_idle", {63'd0, busy}, 64'd0);
    step(8);
    chk("t5_no_frame", {63'd0, out_valid}, 64'd0);
    chk("t5_rd_count", 64'(rd_cnt), 64'd1);
    chk("t5_fifo_drained", {63'd0, l_empty}, 64'd1);

    // Counter saturation, clear priority, mid-run reset.
    clear_test();
    sb_en = 1'b0;
    osr_div = 16'd0;
    enable = 1'b1;
    step(25);
    chk("t6_saturate", 64'(underrun_cnt), 64'd15);
    cnt_clr = 1'b1;
    step(1);
    chk("t6_clr_priority", 64'(underrun_cnt), 64'd0);
    cnt_clr = 1'b0;
    step(1);
    chk("t6_resume", 64'(underrun_cnt), 64'd1);
    rst = 1'b1;
    enable = 1'b0;
    step(1);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_underrun", 64'(underrun_cnt), 64'd0);
    chk("t6_rst_out", {out_l, out_r}, 64'd0);
    rst = 1'b0;
    step(2);
    chk("t6_stays_idle", {63'd0, busy}, 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
